// File: rtl/apu_regop_queue.sv
// Buffers decoded APU register writes ($4000-$4017) and releases them in order,
// one per APU-clock enable slot, as a registered first-word-fall-through FIFO.
module apu_regop_queue #(
    parameter int DEPTH  = 4,
    parameter int IDX_W  = 5,
    parameter int DATA_W = 8
) (
    input  logic                     CLK,
    input  logic                     n_RES,
    input  logic                     ACLK_EN,
    input  logic                     wr_strobe,
    input  logic [IDX_W-1:0]         wr_idx,
    input  logic [DATA_W-1:0]        wr_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [IDX_W-1:0]         out_idx,
    output logic [DATA_W-1:0]        out_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty,
    output logic                     ovf,
    output logic                     bad_idx,
    input  logic                     clr_ovf
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [IDX_W-1:0]  idx_mem  [DEPTH];
    logic [DATA_W-1:0] data_mem [DEPTH];
    logic [PW-1:0]     rd_ptr, wr_ptr;
    logic              idx_ok, deq, accept, drop;

    // Highest legal register is $4017 (index 23); $4014/$4016 pass through untouched.
    assign idx_ok = (32'(wr_idx) <= 32'd23);
    assign full   = (count == CW'(DEPTH));
    assign empty  = (count == '0);
    assign deq    = out_valid & out_ready & ACLK_EN;
    assign accept = wr_strobe & idx_ok & (~full | deq);
    assign drop   = wr_strobe & idx_ok & full & ~deq;

    assign out_valid = ~empty;
    // Head is read from registered storage only, so wr_* never reach out_* combinationally.
    assign out_idx   = empty ? '0 : idx_mem[rd_ptr];
    assign out_data  = empty ? '0 : data_mem[rd_ptr];

    always_ff @(posedge CLK) begin
        if (accept) begin
            idx_mem[wr_ptr]  <= wr_idx;
            data_mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge CLK or negedge n_RES) begin
        if (!n_RES) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count   <= '0;
            ovf     <= 1'b0;
            bad_idx <= 1'b0;
        end else begin
            if (accept) wr_ptr <= wr_ptr + 1'b1;
            if (deq)    rd_ptr <= rd_ptr + 1'b1;
            case ({accept, deq})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            // A new overflow beats a simultaneous clear.
            if (drop)         ovf <= 1'b1;
            else if (clr_ovf) ovf <= 1'b0;
            bad_idx <= wr_strobe & ~idx_ok;
        end
    end
endmodule

// File: tb/tb_apu_regop_queue.sv
// Randomized + directed bench for apu_regop_queue against a queue-based reference model.
module tb_apu_regop_queue;
    localparam int DEPTH = 4;

    logic       CLK = 1'b0, n_RES = 1'b0, ACLK_EN = 1'b0, wr_strobe = 1'b0;
    logic [4:0] wr_idx = '0;
    logic [7:0] wr_data = '0;
    logic       out_ready = 1'b0, clr_ovf = 1'b0;
    logic       out_valid, full, empty, ovf, bad_idx;
    logic [4:0] out_idx;
    logic [7:0] out_data;
    logic [2:0] count;

    apu_regop_queue #(.DEPTH(DEPTH), .IDX_W(5), .DATA_W(8)) dut (
        .CLK(CLK), .n_RES(n_RES), .ACLK_EN(ACLK_EN), .wr_strobe(wr_strobe),
        .wr_idx(wr_idx), .wr_data(wr_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_idx(out_idx), .out_data(out_data), .count(count), .full(full), .empty(empty),
        .ovf(ovf), .bad_idx(bad_idx), .clr_ovf(clr_ovf)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [4:0] idx;
        logic [7:0] data;
    } ent_t;

    ent_t       mq[$];      // model contents, head first
    logic [7:0] got[$];     // data values the model saw dequeued
    logic       m_ovf = 1'b0, m_bad = 1'b0;
    int         tests = 0, fails = 0;
    bit         done = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor/model: samples 3 time units after the negedge drive, checks DUT state
    // against the model, then applies this cycle's inputs to the model.
    initial begin
        while (!done) begin
            @(negedge CLK);
            #3;
            if (!n_RES) begin
                mq.delete();
                m_ovf = 1'b0;
                m_bad = 1'b0;
            end else begin
                bit   deq, vld, was_full;
                ent_t e;
                check("count", 32'(count), 32'(mq.size()));
                check("empty", 32'(empty), 32'(mq.size() == 0));
                check("full", 32'(full), 32'(mq.size() == DEPTH));
                check("out_valid", 32'(out_valid), 32'(mq.size() != 0));
                check("ovf", 32'(ovf), 32'(m_ovf));
                check("bad_idx", 32'(bad_idx), 32'(m_bad));
                if (mq.size() != 0) begin
                    check("head_idx", 32'(out_idx), 32'(mq[0].idx));
                    check("head_data", 32'(out_data), 32'(mq[0].data));
                end
                was_full = (mq.size() == DEPTH);
                deq = (mq.size() != 0) && out_ready && ACLK_EN;
                vld = wr_strobe && (wr_idx <= 5'd23);
                if (deq) begin
                    e = mq.pop_front();
                    got.push_back(e.data);
                end
                if (vld && (!was_full || deq)) begin
                    e.idx = wr_idx;
                    e.data = wr_data;
                    mq.push_back(e);
                end
                if (vld && was_full && !deq) m_ovf = 1'b1;
                else if (clr_ovf)           m_ovf = 1'b0;
                m_bad = wr_strobe && (wr_idx > 5'd23);
            end
        end
    end

    task automatic cyc(input bit s, input logic [4:0] i, input logic [7:0] d,
                       input bit rdy, input bit en, input bit clr);
        @(negedge CLK);
        wr_strobe = s; wr_idx = i; wr_data = d;
        out_ready = rdy; ACLK_EN = en; clr_ovf = clr;
    endtask

    task automatic idle(input bit rdy, input bit en);
        cyc(0, 5'd0, 8'd0, rdy, en, 0);
    endtask

    // Drain with a bounded cycle budget; an expired budget is a failed comparison.
    task automatic drain();
        int n = 0;
        while (mq.size() != 0 && n < 4 * DEPTH + 4) begin
            idle(1, 1);
            n++;
        end
        idle(0, 0);
        check("drain_done", 32'(mq.size()), 32'd0);
    endtask

    task automatic check_got(input string name, input logic [7:0] exp[$]);
        check({name, "_len"}, 32'(got.size()), 32'(exp.size()));
        for (int k = 0; k < exp.size() && k < got.size(); k++)
            check(name, 32'(got[k]), 32'(exp[k]));
    endtask

    initial begin
        logic [7:0] exp[$];
        #1;
        check("rst_count", 32'(count), 32'd0);
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_empty", 32'(empty), 32'd1);
        check("rst_full", 32'(full), 32'd0);
        check("rst_ovf", 32'(ovf), 32'd0);
        check("rst_bad", 32'(bad_idx), 32'd0);
        check("rst_oidx", 32'(out_idx), 32'd0);
        check("rst_odata", 32'(out_data), 32'd0);
        @(negedge CLK);
        n_RES = 1'b1;

        // Single write, fall-through, dequeue next edge
        got.delete();
        cyc(1, 5'h00, 8'h3F, 1, 1, 0);
        idle(1, 1);
        idle(1, 1);
        idle(0, 0);
        exp = '{8'h3F};
        check_got("single", exp);

        // Fill, overflow, ordered drain
        got.delete();
        cyc(1, 5'h02, 8'h11, 0, 1, 0);
        cyc(1, 5'h03, 8'h22, 0, 1, 0);
        cyc(1, 5'h06, 8'h33, 0, 1, 0);
        cyc(1, 5'h07, 8'h44, 0, 1, 0);
        cyc(1, 5'h08, 8'h55, 0, 1, 0);
        idle(0, 1);
        check("ovf_after_drop", 32'(ovf), 32'd1);
        check("full_count", 32'(count), 32'd4);
        drain();
        exp = '{8'h11, 8'h22, 8'h33, 8'h44};
        check_got("fifo_order", exp);
        cyc(0, 5'd0, 8'd0, 0, 0, 1);
        idle(0, 0);

        // Full + simultaneous deq + write: accepted, no overflow
        got.delete();
        cyc(1, 5'h01, 8'hA1, 0, 1, 0);
        cyc(1, 5'h04, 8'hA2, 0, 1, 0);
        cyc(1, 5'h05, 8'hA3, 0, 1, 0);
        cyc(1, 5'h09, 8'hA4, 0, 1, 0);
        cyc(1, 5'h15, 8'h0F, 1, 1, 0);
        idle(0, 0);
        check("full_deq_count", 32'(count), 32'd4);
        check("full_deq_ovf", 32'(ovf), 32'd0);
        drain();
        exp = '{8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'h0F};
        check_got("full_deq_order", exp);

        // ACLK_EN toggling gates dequeues; model checks head stability every cycle
        got.delete();
        cyc(1, 5'h0A, 8'hB1, 1, 0, 0);
        cyc(1, 5'h0B, 8'hB2, 1, 1, 0);
        cyc(1, 5'h0C, 8'hB3, 1, 0, 0);
        for (int k = 0; k < 8; k++) idle(1, k[0]);
        idle(0, 0);
        exp = '{8'hB1, 8'hB2, 8'hB3};
        check_got("aclk_order", exp);

        // Bad index rejected, boundary index accepted
        got.delete();
        cyc(1, 5'h18, 8'hAA, 0, 1, 0);
        cyc(0, 5'd0, 8'd0, 0, 1, 0);
        check("bad_pulse", 32'(bad_idx), 32'd1);
        check("bad_count", 32'(count), 32'd0);
        cyc(1, 5'h1F, 8'hAB, 0, 1, 0);
        cyc(1, 5'h17, 8'hAC, 0, 1, 0);
        idle(0, 0);
        check("bad_clear", 32'(bad_idx), 32'd0);
        check("idx23_count", 32'(count), 32'd1);
        drain();
        exp = '{8'hAC};
        check_got("idx23_data", exp);

        // Overflow with simultaneous clear keeps ovf; then async reset mid-operation
        for (int k = 0; k < DEPTH; k++) cyc(1, 5'(k), 8'(8'hC0 + k), 0, 1, 0);
        cyc(1, 5'h10, 8'hCF, 0, 1, 0);
        cyc(1, 5'h11, 8'hCE, 0, 1, 1);
        idle(0, 0);
        check("ovf_set_wins", 32'(ovf), 32'd1);
        idle(1, 1);
        idle(1, 1);
        idle(0, 0);
        check("two_left", 32'(count), 32'd2);
        @(negedge CLK);
        wr_strobe = 0; out_ready = 0; ACLK_EN = 0; clr_ovf = 0;
        #1 n_RES = 1'b0;
        #1;
        check("arst_count", 32'(count), 32'd0);
        check("arst_valid", 32'(out_valid), 32'd0);
        check("arst_ovf", 32'(ovf), 32'd0);
        @(negedge CLK);
        n_RES = 1'b1;
        idle(0, 0);

        // Randomized traffic
        for (int k = 0; k < 400; k++)
            cyc($urandom_range(0, 2) != 0, 5'($urandom_range(0, 31)), 8'($urandom),
                $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
                $urandom_range(0, 15) == 0);
        drain();
        idle(0, 0);
        done = 1'b1;
        @(negedge CLK);
        #5;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time budget");
        $fatal(1);
    end
endmodule
